// File: rtl/layer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : layer_sequencer_if
//  Purpose  : Bundles the host handshake, weight-RAM read port and
//             accelerator connections of layer_sequencer.
//  Ports    : start/in_vec/busy/out_valid/out_ready/out_vec/layer_idx (host),
//             wgt_rd_en/wgt_addr/wgt_rdata (weight RAM),
//             acc_in/acc_w/acc_out (combinational accelerator).
//  Modports : slave  - the sequencer itself
//             master - the surrounding system (host, RAM, accelerator)
//  Revision : 1.0 - initial release
// ============================================================================
interface layer_sequencer_if #(
    parameter int N  = 15,
    parameter int LW = 2
);
    logic                  start;
    logic [16*N-1:0]       in_vec;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [16*N-1:0]       out_vec;
    logic [LW-1:0]         layer_idx;
    logic                  wgt_rd_en;
    logic [LW-1:0]         wgt_addr;
    logic [16*N*N-1:0]     wgt_rdata;
    logic [16*N-1:0]       acc_in;
    logic [16*N*N-1:0]     acc_w;
    logic [16*N-1:0]       acc_out;

    modport slave (
        input  start, in_vec, out_ready, wgt_rdata, acc_out,
        output busy, out_valid, out_vec, layer_idx, wgt_rd_en, wgt_addr,
               acc_in, acc_w
    );

    modport master (
        output start, in_vec, out_ready, wgt_rdata, acc_out,
        input  busy, out_valid, out_vec, layer_idx, wgt_rd_en, wgt_addr,
               acc_in, acc_w
    );
endinterface
`default_nettype wire

// File: rtl/layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : layer_sequencer
//  Purpose  : Runs NUM_LAYERS fully-connected layers on one shared
//             combinational N-in/N-out accelerator. Per layer: fetch the
//             weight block, load it, let the accelerator settle, capture the
//             (optionally ReLU'd) result as the next layer's activations.
//  Ports    : clk    - clock, rising edge
//             rst_n  - asynchronous active-low reset
//             bus    - layer_sequencer_if.slave (host / weight RAM / accel)
//  Revision : 1.0 - initial release
// ============================================================================
module layer_sequencer #(
    parameter int N          = 15,
    parameter int NUM_LAYERS = 3,
    parameter int SETTLE     = 2,
    parameter bit RELU_LAST  = 1'b0,
    parameter int LW         = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    layer_sequencer_if.slave   bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(SETTLE - 1);
    localparam logic [LW-1:0] LAYER_LAST = LW'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LW-1:0]       layer_q, layer_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [16*N-1:0]     act_q,   act_d;
    logic [16*N*N-1:0]   w_q,     w_d;

    logic                last_layer;
    logic                relu_en;
    logic [16*N-1:0]     act_next;

    assign last_layer = (layer_q == LAYER_LAST);
    // Hidden layers always rectify; the output layer only when RELU_LAST is set.
    assign relu_en    = !last_layer || RELU_LAST;

    // Result of the current layer as it will be written back into act_q.
    always_comb begin
        act_next = bus.acc_out;
        for (int j = 0; j < N; j++) begin
            if (relu_en && bus.acc_out[16*j+15]) begin
                act_next[16*j +: 16] = 16'h0000;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        cnt_d   = cnt_q;
        act_d   = act_q;
        w_d     = w_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    act_d   = bus.in_vec;
                    layer_d = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                // RAM data is valid in the cycle after the read strobe.
                w_d     = bus.wgt_rdata;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                // acc_out is a multicycle path from act_q/w_q; it is only
                // sampled on the last settle cycle.
                if (cnt_q == CNT_LAST) begin
                    act_d = act_next;
                    if (last_layer) begin
                        state_d = S_DONE;
                    end else begin
                        layer_d = layer_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            layer_q <= '0;
            cnt_q   <= '0;
            act_q   <= '0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
            w_q     <= w_d;
        end
    end

    assign bus.busy      = (state_q == S_FETCH) || (state_q == S_LOAD) ||
                           (state_q == S_SETTLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.out_vec   = act_q;
    assign bus.layer_idx = layer_q;
    assign bus.wgt_rd_en = (state_q == S_FETCH);
    assign bus.wgt_addr  = layer_q;
    assign bus.acc_in    = act_q;
    assign bus.acc_w     = w_q;
endmodule
`default_nettype wire

// File: tb/tb_layer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_sequencer
//  Purpose  : Self-checking bench for layer_sequencer with a behavioural
//             accelerator and weight RAM holding diagonal weight sets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_layer_sequencer;
    localparam int N  = 15;
    localparam int NL = 3;
    localparam int LW = 2;
    localparam int VW = 16*N;
    localparam int WW = 16*N*N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    layer_sequencer_if #(.N(N), .LW(LW)) bus ();

    layer_sequencer #(.N(N), .NUM_LAYERS(NL), .SETTLE(2), .RELU_LAST(1'b0), .LW(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cur_sel = 0;
    logic [LW-1:0] rd_q[$];

    // Diagonal weight per (set, layer); everything off-diagonal is zero.
    function automatic logic [15:0] diag(input int sel, input int layer);
        case (sel)
            1:       return (layer == 0) ? 16'hFFFF : 16'h0001;
            2:       return (layer == 0) ? 16'h0002 : (layer == 1) ? 16'h0001 : 16'hFFFF;
            default: return 16'h0001;
        endcase
    endfunction

    function automatic logic [WW-1:0] wblock(input int sel, input int layer);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < N; i++) w[16*(i*N+i) +: 16] = diag(sel, layer);
        return w;
    endfunction

    // out[i] = sum_j in[j] * w[i*N+j], truncated to 16 bits.
    function automatic logic [VW-1:0] acc_model(input logic [VW-1:0] a, input logic [WW-1:0] w);
        logic [VW-1:0] r;
        logic signed [31:0] s;
        logic signed [15:0] x, y;
        r = '0;
        for (int i = 0; i < N; i++) begin
            s = 0;
            for (int j = 0; j < N; j++) begin
                x = a[16*j +: 16];
                y = w[16*(i*N+j) +: 16];
                s = s + x * y;
            end
            r[16*i +: 16] = s[15:0];
        end
        return r;
    endfunction

    assign bus.acc_out = acc_model(bus.acc_in, bus.acc_w);

    always @(posedge clk) begin
        if (bus.wgt_rd_en) bus.wgt_rdata <= wblock(cur_sel, int'(bus.wgt_addr));
    end

    always @(negedge clk) begin
        if (bus.wgt_rd_en) rd_q.push_back(bus.wgt_addr);
    end

    typedef struct {
        logic [VW-1:0] vin;
        logic [VW-1:0] vhid;
        logic [VW-1:0] vexp;
        int            sel;
    } vec_t;
    vec_t vecs[5];

    task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Call at a negedge while IDLE; returns at the negedge after the accept edge.
    task automatic start_inf(input logic [VW-1:0] v, input int sel);
        cur_sel = sel;
        rd_q.delete();
        bus.in_vec = v;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.in_vec = ~v;
        chk("busy_after_start", VW'(bus.busy), VW'(1));
    endtask

    task automatic wait_valid(input int pulse_at, output int cyc, output logic [VW-1:0] hid);
        cyc = 0;
        hid = '0;
        while (!bus.out_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (cyc == 5) hid = bus.acc_in;
            if (pulse_at >= 0) bus.start = (cyc == pulse_at);
        end
        bus.start = 1'b0;
    endtask

    task automatic handshake();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hs_out_valid", VW'(bus.out_valid), VW'(0));
        chk("hs_busy", VW'(bus.busy), VW'(0));
    endtask

    task automatic chk_reads();
        chk("n_reads", VW'(rd_q.size()), VW'(3));
        for (int k = 0; k < rd_q.size() && k < 3; k++)
            chk($sformatf("rd_addr%0d", k), VW'(rd_q[k]), VW'(k));
    endtask

    task automatic run_check(input int k, input int pulse_at);
        int cyc;
        logic [VW-1:0] hid;
        start_inf(vecs[k].vin, vecs[k].sel);
        wait_valid(pulse_at, cyc, hid);
        chk($sformatf("v%0d_latency", k), VW'(cyc), VW'(12));
        chk($sformatf("v%0d_hidden", k), hid, vecs[k].vhid);
        chk($sformatf("v%0d_out_vec", k), bus.out_vec, vecs[k].vexp);
        chk($sformatf("v%0d_busy_done", k), VW'(bus.busy), VW'(0));
        chk_reads();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_vec = '0;

        for (int k = 0; k < 5; k++) begin
            vecs[k].vin = '0; vecs[k].vhid = '0; vecs[k].vexp = '0;
        end
        for (int j = 0; j < N; j++) begin
            vecs[0].vin[16*j +: 16]  = 16'(j+1);
            vecs[0].vhid[16*j +: 16] = 16'(j+1);
            vecs[0].vexp[16*j +: 16] = 16'(j+1);
            if (j == 14) begin
                vecs[1].vin[16*j +: 16]  = 16'h7FFF;
                vecs[1].vhid[16*j +: 16] = 16'h7FFF;
                vecs[1].vexp[16*j +: 16] = 16'h7FFF;
            end else if (j % 2 == 0) begin
                vecs[1].vin[16*j +: 16]  = 16'(-(j+1));
            end else begin
                vecs[1].vin[16*j +: 16]  = 16'(j+1);
                vecs[1].vhid[16*j +: 16] = 16'(j+1);
                vecs[1].vexp[16*j +: 16] = 16'(j+1);
            end
            vecs[4].vin[16*j +: 16]  = 16'(j+1);
            vecs[4].vhid[16*j +: 16] = 16'(2*(j+1));
            vecs[4].vexp[16*j +: 16] = 16'(-2*(j+1));
        end
        vecs[0].sel = 0;
        vecs[1].sel = 0;
        vecs[2].vin[15:0] = 16'd5;        vecs[2].sel = 1;
        vecs[3].vin[15:0] = 16'hFFFB;     vecs[3].sel = 1;
        vecs[3].vhid[15:0] = 16'd5;       vecs[3].vexp[15:0] = 16'd5;
        vecs[4].sel = 2;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", VW'(bus.busy), VW'(0));
        chk("rst_out_valid", VW'(bus.out_valid), VW'(0));
        chk("rst_wgt_rd_en", VW'(bus.wgt_rd_en), VW'(0));
        chk("rst_layer_idx", VW'(bus.layer_idx), VW'(0));
        chk("rst_acc_in", bus.acc_in, '0);
        chk("rst_acc_w_nonzero", VW'(|bus.acc_w), VW'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven inferences
        for (int k = 0; k < 5; k++) begin
            run_check(k, -1);
            handshake();
            @(negedge clk);
        end

        // Backpressure: hold out_ready low for 10 cycles
        run_check(0, -1);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!bus.out_valid || bus.busy || bus.out_vec !== vecs[0].vexp) ok = 1'b0;
        end
        chk("bp_hold", VW'(ok), VW'(1));
        handshake();
        @(negedge clk);

        // Ignored start: during layer 1, during DONE and with the handshake
        run_check(3, 5);
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        chk("done_start_valid", VW'(bus.out_valid), VW'(1));
        chk("done_start_busy", VW'(bus.busy), VW'(0));
        chk("done_start_vec", bus.out_vec, vecs[3].vexp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        chk("hs_start_valid", VW'(bus.out_valid), VW'(0));
        @(negedge clk);
        chk("hs_start_not_accepted", VW'(bus.busy), VW'(0));
        chk("hs_start_no_read", VW'(rd_q.size()), VW'(3));
        @(negedge clk);

        // Back-to-back: new start on the cycle after the handshake
        run_check(4, -1);
        handshake();
        run_check(1, -1);
        handshake();
        @(negedge clk);

        // Reset mid-SETTLE of layer 1
        start_inf(vecs[0].vin, 0);
        repeat (6) @(negedge clk);
        chk("pre_rst_layer_idx", VW'(bus.layer_idx), VW'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", VW'(bus.busy), VW'(0));
        chk("mid_rst_out_valid", VW'(bus.out_valid), VW'(0));
        chk("mid_rst_wgt_rd_en", VW'(bus.wgt_rd_en), VW'(0));
        chk("mid_rst_layer_idx", VW'(bus.layer_idx), VW'(0));
        chk("mid_rst_wgt_addr", VW'(bus.wgt_addr), VW'(0));
        chk("mid_rst_out_vec", bus.out_vec, '0);
        chk("mid_rst_acc_w_nonzero", VW'(|bus.acc_w), VW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid || bus.busy || bus.wgt_rd_en) ok = 1'b0;
        end
        chk("post_rst_idle", VW'(ok), VW'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
